fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/types_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg
//   Shared fetch-path types and sizing helpers.
//   DATA_BUS     : width of instruction and address words.
//   fetch_entry  : one queued fetch (instruction word + its PC).
//   ptrWidth()   : read/write pointer width for a given queue depth.
//   countWidth() : occupancy counter width; one extra bit so "full" is
//                  representable.
// -----------------------------------------------------------------------------
package types_pkg;

  localparam int DATA_BUS = 32;

  typedef struct packed {
    logic [DATA_BUS-1:0] instr;
    logic [DATA_BUS-1:0] pc;
  } fetch_entry;

  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Small FIFO between instruction fetch and decode. Entries carry the
//   instruction word and its PC; the head also presents PC + 4. A flush from
//   execute (taken branch/jump) empties the queue and refuses the entry
//   offered in the same cycle.
//
//   Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, the
//   offered entry is routed straight to the decode side in the same cycle and,
//   if decode takes it, it is never written into storage.
//
// Parameters
//   DEPTH          number of entries; power of two, 2..16
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   enq_valid_i    fetch offers an entry
//   enq_ready_o    queue accepts the offered entry
//   enq_instr_i    offered instruction word
//   enq_pc_i       PC of the offered instruction
//   deq_valid_o    head entry presented to decode
//   deq_ready_i    decode consumes the head entry
//   deq_instr_o    head instruction
//   deq_pc_o       head PC
//   deq_pcplus4_o  head PC + 4 (wraps modulo 2^32)
//   flush_i        discard all entries
//   count_o        occupancy
// -----------------------------------------------------------------------------
module fetch_queue
  import types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enq_valid_i,
  output logic                          enq_ready_o,
  input  logic [DATA_BUS-1:0]           enq_instr_i,
  input  logic [DATA_BUS-1:0]           enq_pc_i,
  output logic                          deq_valid_o,
  input  logic                          deq_ready_i,
  output logic [DATA_BUS-1:0]           deq_instr_o,
  output logic [DATA_BUS-1:0]           deq_pc_o,
  output logic [DATA_BUS-1:0]           deq_pcplus4_o,
  input  logic                          flush_i,
  output logic [countWidth(DEPTH)-1:0]  count_o
);

  localparam int PTR_W = ptrWidth(DEPTH);
  localparam int CNT_W = countWidth(DEPTH);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  fetch_entry        entries [DEPTH];
  fetch_entry        headEntry;
  fetch_entry        enqEntry;
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;
  logic              isEmpty;
  logic              isFull;
  logic              doPush;
  logic              doPop;

  assign isEmpty   = (count == '0);
  assign isFull    = (count == FULL_COUNT);
  assign enqEntry  = '{instr: enq_instr_i, pc: enq_pc_i};
  assign headEntry = entries[rdPtr];

  // Ready looks only at occupancy and flush, never at deq_ready_i, so fetch
  // never sees a combinational loop through decode.
  assign enq_ready_o = !isFull && !flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypassActive;

  assign bypassActive = isEmpty && !flush_i;

  // NOTE: every output gets a value on every path through this block; a
  // missing assignment in one branch would infer a latch.
  always_comb begin
    if (bypassActive) begin
      deq_valid_o = enq_valid_i;
      deq_instr_o = enq_instr_i;
      deq_pc_o    = enq_pc_i;
    end else begin
      deq_valid_o = !isEmpty && !flush_i;
      deq_instr_o = headEntry.instr;
      deq_pc_o    = headEntry.pc;
    end
  end

  // An entry that passes straight through to decode is not stored.
  assign doPush = enq_valid_i && enq_ready_o && !(bypassActive && deq_ready_i);
  assign doPop  = deq_valid_o && deq_ready_i && !bypassActive;
`else
  assign deq_valid_o = !isEmpty && !flush_i;
  assign deq_instr_o = headEntry.instr;
  assign deq_pc_o    = headEntry.pc;

  assign doPush = enq_valid_i && enq_ready_o;
  assign doPop  = deq_valid_o && deq_ready_i;
`endif

  assign deq_pcplus4_o = deq_pc_o + DATA_BUS'(4);
  assign count_o       = count;

  // Pointers wrap for free because DEPTH is a power of two.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush_i) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry storage has no reset; validity is tracked entirely by count
  // and the pointers, so stale words are never presented as valid.
  always_ff @(posedge clk) begin
    if (doPush) entries[wrPtr] <= enqEntry;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Bench for fetch_queue (DEPTH = 4). The driver issues directed cycles and
//   pushes every entry it expects the queue to accept into a scoreboard; a
//   separate monitor pops and compares whenever decode takes the head entry.
//   Honours FETCH_QUEUE_BYPASS_EN where expected values differ.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
  } expEntry;

  logic        clk;
  logic        rst;
  logic        enq_valid_i;
  logic        enq_ready_o;
  logic [31:0] enq_instr_i;
  logic [31:0] enq_pc_i;
  logic        deq_valid_o;
  logic        deq_ready_i;
  logic [31:0] deq_instr_o;
  logic [31:0] deq_pc_o;
  logic [31:0] deq_pcplus4_o;
  logic        flush_i;
  logic [2:0]  count_o;

  expEntry sbQ[$];
  int      nChecks = 0;
  int      nFails  = 0;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  fetch_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .enq_valid_i   (enq_valid_i),
    .enq_ready_o   (enq_ready_o),
    .enq_instr_i   (enq_instr_i),
    .enq_pc_i      (enq_pc_i),
    .deq_valid_o   (deq_valid_o),
    .deq_ready_i   (deq_ready_i),
    .deq_instr_o   (deq_instr_o),
    .deq_pc_o      (deq_pc_o),
    .deq_pcplus4_o (deq_pcplus4_o),
    .flush_i       (flush_i),
    .count_o       (count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic expectAccept);
    expEntry e;
    enq_valid_i = v;
    enq_instr_i = instr;
    enq_pc_i    = pc;
    deq_ready_i = rdy;
    flush_i     = fl;
    if (expectAccept) begin
      e.instr   = instr;
      e.pc      = pc;
      e.pcPlus4 = pc + 32'd4;
      sbQ.push_back(e);
    end
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  // Monitor: a dequeue handshake is sampled on the falling edge, halfway
  // before the rising edge that completes it.
  initial begin
    expEntry e;
    forever begin
      @(negedge clk);
      if (rst && deq_valid_o && deq_ready_i) begin
        if (sbQ.size() == 0) begin
          check("unexpected_dequeue_pc", deq_pc_o, 32'hxxxxxxxx);
        end else begin
          e = sbQ.pop_front();
          check("sb_instr",   deq_instr_o,   e.instr);
          check("sb_pc",      deq_pc_o,      e.pc);
          check("sb_pcplus4", deq_pcplus4_o, e.pcPlus4);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    enq_valid_i = 1'b0;
    enq_instr_i = '0;
    enq_pc_i    = '0;
    deq_ready_i = 1'b0;
    flush_i     = 1'b0;

    // Reset state, before any clock edge.
    #3;
    check("rst_deq_valid", 32'(deq_valid_o), 32'd0);
    check("rst_enq_ready", 32'(enq_ready_o), 32'd1);
    check("rst_count",     32'(count_o),     32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset then single entry.
    step();
    drive(1'b1, 32'h00500093, 32'hBFC00000, 1'b0, 1'b0, 1'b1);
    #2;
    check("single_same_cycle_valid", 32'(deq_valid_o), BYPASS ? 32'd1 : 32'd0);
    if (BYPASS) check("single_bypass_pcplus4", deq_pcplus4_o, 32'hBFC00004);
    step();
    idle(1'b1);
    #2;
    check("single_valid",   32'(deq_valid_o), 32'd1);
    check("single_pcplus4", deq_pcplus4_o,    32'hBFC00004);
    check("single_count",   32'(count_o),     32'd1);
    step();
    idle(1'b0);
    #2;
    check("single_drained", 32'(count_o), 32'd0);

    // Fill and backpressure.
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1'b1, 32'h10000000 | 32'(i), 32'(4 * i), 1'b0, 1'b0, 1'b1);
    end
    step();
    drive(1'b1, 32'h10000004, 32'h10, 1'b0, 1'b0, 1'b0);
    #2;
    check("full_count",     32'(count_o),     32'd4);
    check("full_enq_ready", 32'(enq_ready_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      idle(1'b1);
    end
    step();
    idle(1'b0);
    #2;
    check("fill_drained_count", 32'(count_o),     32'd0);
    check("fill_drained_valid", 32'(deq_valid_o), 32'd0);

    // Wrap-around: continuous enqueue and dequeue of 10 entries.
    for (int i = 0; i <= 10; i++) begin
      step();
      if (i < 10) drive(1'b1, 32'h20000000 | 32'(i), 32'h1000 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
      else        idle(1'b1);
      #2;
      if (i > 0) check("wrap_count", 32'(count_o), BYPASS ? 32'd0 : 32'd1);
    end
    step();
    idle(1'b0);
    #2;
    check("wrap_drained", 32'(count_o), 32'd0);

    // Flush with three entries queued, offering pc 0x20 in the flush cycle.
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1'b1, 32'h30000000 | 32'(i), 32'h2000 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
    end
    step();
    drive(1'b1, 32'h30000020, 32'h20, 1'b1, 1'b1, 1'b0);
    #2;
    check("flush_deq_valid", 32'(deq_valid_o), 32'd0);
    check("flush_enq_ready", 32'(enq_ready_o), 32'd0);
    step();
    sbQ.delete();
    idle(1'b0);
    #2;
    check("flush_count", 32'(count_o),     32'd0);
    check("flush_valid", 32'(deq_valid_o), 32'd0);
    // The next entry must be the only one present, read from slot 0.
    step();
    drive(1'b1, 32'h30000030, 32'h30, 1'b0, 1'b0, 1'b1);
    step();
    idle(1'b1);
    #2;
    check("post_flush_pc",    deq_pc_o,         32'h30);
    check("post_flush_count", 32'(count_o),     32'd1);
    step();
    idle(1'b0);

    // Mid-operation reset between clock edges.
    for (int i = 0; i < 2; i++) begin
      step();
      drive(1'b1, 32'h40000000 | 32'(i), 32'h3000 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
    end
    step();
    idle(1'b0);
    #2;
    check("pre_reset_count", 32'(count_o), 32'd2);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_count",     32'(count_o),     32'd0);
    check("async_reset_deq_valid", 32'(deq_valid_o), 32'd0);
    check("async_reset_enq_ready", 32'(enq_ready_o), 32'd1);
    sbQ.delete();
    step();
    #2;
    rst = 1'b1;
    step();
    idle(1'b1);
    #2;
    check("post_reset_valid", 32'(deq_valid_o), 32'd0);
    check("post_reset_count", 32'(count_o),     32'd0);

    // PC wrap on the +4 output.
    step();
    drive(1'b1, 32'hDEADBEEF, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1);
    step();
    idle(1'b1);
    #2;
    check("pcwrap_pc",      deq_pc_o,      32'hFFFFFFFC);
    check("pcwrap_pcplus4", deq_pcplus4_o, 32'h00000000);
    step();
    idle(1'b0);

    step();
    step();
    check("scoreboard_drained", 32'(sbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
